// File: rtl/alu_mc.sv
// Multi-cycle execute-stage ALU: single-cycle logic/arith ops plus iterative
// shift-add multiply and restoring divide/remainder behind valid/ready handshakes.
module alu_mc #(
    parameter int WIDTH     = 32,
    parameter int IMM_WIDTH = 21
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [3:0]           opcode,
    input  logic                 addressing_mode,
    input  logic [WIDTH-1:0]     reg_a_data,
    input  logic [WIDTH-1:0]     reg_b_data,
    input  logic [IMM_WIDTH-1:0] immediate,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     result,
    output logic [3:0]           cmp_result,
    output logic                 div_zero,
    output logic                 illegal
);

    localparam int               CW    = $clog2(WIDTH + 1);
    localparam logic [WIDTH-1:0] W_VAL = WIDTH'(WIDTH);

    localparam logic [3:0] OP_LDR = 4'b0000, OP_STR = 4'b0001, OP_ADD = 4'b0010,
                           OP_SUB = 4'b0011, OP_MOV = 4'b0100, OP_MUL = 4'b0101,
                           OP_DIVU = 4'b0110, OP_REMU = 4'b0111, OP_AND = 4'b1000,
                           OP_ORR = 4'b1001, OP_EOR = 4'b1010, OP_MVN = 4'b1011,
                           OP_LSL = 4'b1100, OP_LSR = 4'b1101, OP_ILL = 4'b1111;

    typedef enum logic [1:0] {ST_IDLE, ST_MUL, ST_DIV, ST_DONE} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [3:0]       cmp_q, cmp_d;
    logic             dz_q, dz_d, ill_q, ill_d;
    // Working registers: acc is the product accumulator or partial remainder,
    // sh is the shifting multiplicand or dividend/quotient, mpl the multiplier.
    logic [WIDTH-1:0] op1_q, op1_d, op2_q, op2_d;
    logic [WIDTH-1:0] acc_q, acc_d, sh_q, sh_d, mpl_q, mpl_d;
    logic             rem_sel_q, rem_sel_d;

    logic [WIDTH-1:0] imm_ext, op2_in, mul_acc, rem_nx, quo_nx;
    logic [WIDTH:0]   rem_sh, rem_diff;
    logic             accept, div_ok, last;

    generate
        if (IMM_WIDTH >= WIDTH) begin : g_imm_trunc
            assign imm_ext = immediate[WIDTH-1:0];
        end else begin : g_imm_zext
            assign imm_ext = {{(WIDTH - IMM_WIDTH){1'b0}}, immediate};
        end
    endgenerate

    function automatic logic [WIDTH-1:0] alu_fn(input logic [3:0] op,
                                                input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b);
        logic [WIDTH-1:0] r;
        r = '0;
        case (op)
            OP_LDR, OP_STR, OP_MOV: r = b;
            OP_ADD:                 r = a + b;
            OP_SUB:                 r = a - b;
            OP_AND:                 r = a & b;
            OP_ORR:                 r = a | b;
            OP_EOR:                 r = a ^ b;
            OP_MVN:                 r = ~b;
            OP_LSL:                 r = (b >= W_VAL) ? '0 : (a << b);
            OP_LSR:                 r = (b >= W_VAL) ? '0 : (a >> b);
            default:                r = '0;
        endcase
        return r;
    endfunction

    function automatic logic [3:0] cmp_fn(input logic [WIDTH-1:0] a,
                                          input logic [WIDTH-1:0] b);
        return {a > b, a < b, a != b, a == b};
    endfunction

    assign op2_in    = addressing_mode ? reg_b_data : imm_ext;
    assign in_ready  = (state_q == ST_IDLE) || ((state_q == ST_DONE) && out_ready);
    assign accept    = in_valid && in_ready;
    assign out_valid = (state_q == ST_DONE);
    assign last      = (cnt_q == CW'(WIDTH - 1));

    // One shift-add step and one restoring-division step, shared by the FSM.
    assign mul_acc  = acc_q + (mpl_q[0] ? sh_q : '0);
    assign rem_sh   = {acc_q, sh_q[WIDTH-1]};
    assign rem_diff = rem_sh - {1'b0, op2_q};
    assign div_ok   = !rem_diff[WIDTH];
    assign rem_nx   = div_ok ? rem_diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
    assign quo_nx   = {sh_q[WIDTH-2:0], div_ok};

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        result_d  = result_q;
        cmp_d     = cmp_q;
        dz_d      = dz_q;
        ill_d     = ill_q;
        op1_d     = op1_q;
        op2_d     = op2_q;
        acc_d     = acc_q;
        sh_d      = sh_q;
        mpl_d     = mpl_q;
        rem_sel_d = rem_sel_q;

        case (state_q)
            ST_MUL: begin
                acc_d = mul_acc;
                sh_d  = sh_q << 1;
                mpl_d = mpl_q >> 1;
                cnt_d = cnt_q + CW'(1);
                if (last) begin
                    state_d  = ST_DONE;
                    result_d = mul_acc;
                    cmp_d    = cmp_fn(op1_q, op2_q);
                    dz_d     = 1'b0;
                    ill_d    = 1'b0;
                end
            end
            ST_DIV: begin
                acc_d = rem_nx;
                sh_d  = quo_nx;
                cnt_d = cnt_q + CW'(1);
                if (last) begin
                    state_d  = ST_DONE;
                    result_d = rem_sel_q ? rem_nx : quo_nx;
                    cmp_d    = cmp_fn(op1_q, op2_q);
                    dz_d     = (op2_q == '0);
                    ill_d    = 1'b0;
                end
            end
            ST_DONE: begin
                if (out_ready) state_d = ST_IDLE;
            end
            default: ;
        endcase

        // Accept is only possible from IDLE or a draining DONE; it overrides the above.
        if (accept) begin
            op1_d     = reg_a_data;
            op2_d     = op2_in;
            acc_d     = '0;
            sh_d      = reg_a_data;
            mpl_d     = op2_in;
            cnt_d     = '0;
            rem_sel_d = (opcode == OP_REMU);
            case (opcode)
                OP_MUL:           state_d = ST_MUL;
                OP_DIVU, OP_REMU: state_d = ST_DIV;
                default: begin
                    state_d  = ST_DONE;
                    result_d = alu_fn(opcode, reg_a_data, op2_in);
                    cmp_d    = cmp_fn(reg_a_data, op2_in);
                    dz_d     = 1'b0;
                    ill_d    = (opcode == OP_ILL);
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            result_q <= '0;
            cmp_q    <= 4'b0001;
            dz_q     <= 1'b0;
            ill_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            cmp_q    <= cmp_d;
            dz_q     <= dz_d;
            ill_q    <= ill_d;
        end
    end

    always_ff @(posedge clk) begin
        op1_q     <= op1_d;
        op2_q     <= op2_d;
        acc_q     <= acc_d;
        sh_q      <= sh_d;
        mpl_q     <= mpl_d;
        rem_sel_q <= rem_sel_d;
    end

    assign result     = result_q;
    assign cmp_result = cmp_q;
    assign div_zero   = dz_q;
    assign illegal    = ill_q;

endmodule

// File: tb/tb_alu_mc.sv
// Scoreboard bench for alu_mc: a 32-bit instance for the full opcode set and
// handshake behaviour, and an 8-bit instance for the narrow-width iterative ops.
module tb_alu_mc;

    typedef struct {
        string       nm;
        logic [31:0] res;
        logic [3:0]  cmp;
        logic        dz;
        logic        ill;
        int          lat;
    } exp_t;

    logic        clk, rst_n;
    logic        in_valid, in_ready, addressing_mode, out_valid, out_ready;
    logic [3:0]  opcode, cmp_result;
    logic [31:0] reg_a_data, reg_b_data, result;
    logic [20:0] immediate;
    logic        div_zero, illegal;

    logic        in_valid8, in_ready8, mode8, out_valid8, out_ready8;
    logic [3:0]  opcode8, cmp8, imm8;
    logic [7:0]  a8, b8, result8;
    logic        dz8, ill8;

    int checks = 0, failures = 0;
    int cyc = 0;
    exp_t exp32[$], exp8[$];
    int   acc32[$], acc8[$];
    logic pend32 = 0, pend8 = 0;
    logic [31:0] snap_res;
    logic [6:0]  snap_flags;

    alu_mc #(.WIDTH(32), .IMM_WIDTH(21)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .opcode(opcode), .addressing_mode(addressing_mode),
        .reg_a_data(reg_a_data), .reg_b_data(reg_b_data), .immediate(immediate),
        .out_valid(out_valid), .out_ready(out_ready), .result(result),
        .cmp_result(cmp_result), .div_zero(div_zero), .illegal(illegal));

    alu_mc #(.WIDTH(8), .IMM_WIDTH(4)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
        .opcode(opcode8), .addressing_mode(mode8),
        .reg_a_data(a8), .reg_b_data(b8), .immediate(imm8),
        .out_valid(out_valid8), .out_ready(out_ready8), .result(result8),
        .cmp_result(cmp8), .div_zero(dz8), .illegal(ill8));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s got=%h expected=%h", nm, act, expv);
        end
    endtask

    task automatic cmp_out(input exp_t e, input int lat, input logic [31:0] r,
                           input logic [3:0] c, input logic d, input logic i);
        chk({e.nm, ".result"}, r, e.res);
        chk({e.nm, ".cmp"}, {28'd0, c}, {28'd0, e.cmp});
        chk({e.nm, ".div_zero"}, {31'd0, d}, {31'd0, e.dz});
        chk({e.nm, ".illegal"}, {31'd0, i}, {31'd0, e.ill});
        chk({e.nm, ".latency"}, lat, e.lat);
    endtask

    // Monitor for the 32-bit instance: checks each fresh result and its stability while held.
    always @(negedge clk) begin
        exp_t e;
        int   a;
        cyc++;
        if (!rst_n) begin
            exp32.delete();
            acc32.delete();
            pend32 = 1'b0;
        end else begin
            if (out_valid && !pend32) begin
                if (exp32.size() == 0 || acc32.size() == 0) begin
                    chk("unexpected_output", {31'd0, out_valid}, 32'd0);
                end else begin
                    e = exp32.pop_front();
                    a = acc32.pop_front();
                    cmp_out(e, cyc - a, result, cmp_result, div_zero, illegal);
                end
                snap_res   = result;
                snap_flags = {cmp_result, div_zero, illegal, in_ready};
                pend32     = 1'b1;
            end else if (out_valid && pend32 && !out_ready) begin
                chk("stall.result_stable", result, snap_res);
                chk("stall.flags_stable", {25'd0, cmp_result, div_zero, illegal, in_ready},
                    {25'd0, snap_flags});
            end
            if (!out_valid || out_ready) pend32 = 1'b0;
            if (in_valid && in_ready) acc32.push_back(cyc);
        end
    end

    always @(negedge clk) begin
        exp_t e;
        int   a;
        if (!rst_n) begin
            exp8.delete();
            acc8.delete();
            pend8 = 1'b0;
        end else begin
            if (out_valid8 && !pend8) begin
                if (exp8.size() == 0 || acc8.size() == 0) begin
                    chk("unexpected_output8", {31'd0, out_valid8}, 32'd0);
                end else begin
                    e = exp8.pop_front();
                    a = acc8.pop_front();
                    cmp_out(e, cyc - a, {24'd0, result8}, cmp8, dz8, ill8);
                end
                pend8 = 1'b1;
            end
            if (!out_valid8 || out_ready8) pend8 = 1'b0;
            if (in_valid8 && in_ready8) acc8.push_back(cyc);
        end
    end

    task automatic issue(input string nm, input logic [3:0] op, input logic m,
                         input logic [31:0] a, input logic [31:0] b, input logic [20:0] imm,
                         input logic [31:0] er, input logic [3:0] ec, input logic edz,
                         input logic eil, input int elat);
        int n;
        exp_t e;
        e = '{nm: nm, res: er, cmp: ec, dz: edz, ill: eil, lat: elat};
        exp32.push_back(e);
        opcode = op; addressing_mode = m; reg_a_data = a; reg_b_data = b; immediate = imm;
        in_valid = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!in_ready && n < 100);
        if (!in_ready) chk({nm, ".accept_timeout"}, 32'd0, 32'd1);
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic issue8(input string nm, input logic [3:0] op, input logic m,
                          input logic [7:0] a, input logic [7:0] b, input logic [3:0] imm,
                          input logic [7:0] er, input logic [3:0] ec, input int elat);
        int n;
        exp_t e;
        e = '{nm: nm, res: {24'd0, er}, cmp: ec, dz: 1'b0, ill: 1'b0, lat: elat};
        exp8.push_back(e);
        opcode8 = op; mode8 = m; a8 = a; b8 = b; imm8 = imm;
        in_valid8 = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!in_ready8 && n < 100);
        if (!in_ready8) chk({nm, ".accept_timeout"}, 32'd0, 32'd1);
        @(posedge clk);
        #1 in_valid8 = 1'b0;
    endtask

    task automatic drain();
        int n;
        for (n = 0; n < 200 && (exp32.size() != 0 || exp8.size() != 0); n++) @(posedge clk);
        if (exp32.size() != 0 || exp8.size() != 0)
            chk("drain_timeout", exp32.size() + exp8.size(), 32'd0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; opcode = '0; addressing_mode = 1'b0;
        reg_a_data = '0; reg_b_data = '0; immediate = '0;
        in_valid8 = 1'b0; out_ready8 = 1'b1; opcode8 = '0; mode8 = 1'b0;
        a8 = '0; b8 = '0; imm8 = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset.out_valid", {31'd0, out_valid}, 32'd0);
        chk("reset.result", result, 32'd0);
        chk("reset.cmp", {28'd0, cmp_result}, 32'd1);
        chk("reset.flags", {30'd0, div_zero, illegal}, 32'd0);
        rst_n = 1'b1;
        #1 chk("reset.in_ready", {31'd0, in_ready}, 32'd1);

        issue("add", 4'b0010, 1'b1, 32'd7, 32'd5, 21'd0, 32'd12, 4'b1010, 0, 0, 1);
        issue("mov_imm", 4'b0100, 1'b0, 32'd0, 32'd0, 21'h1FFFFF, 32'h001FFFFF, 4'b0110, 0, 0, 1);
        issue("mvn_imm", 4'b1011, 1'b0, 32'd0, 32'd0, 21'h1FFFFF, 32'hFFE00000, 4'b0110, 0, 0, 1);
        issue("mul", 4'b0101, 1'b1, 32'h00010003, 32'h10, 21'd0, 32'h00100030, 4'b1010, 0, 0, 33);
        issue("divu", 4'b0110, 1'b1, 32'd100, 32'd7, 21'd0, 32'd14, 4'b1010, 0, 0, 33);
        issue("remu", 4'b0111, 1'b1, 32'd100, 32'd7, 21'd0, 32'd2, 4'b1010, 0, 0, 33);
        issue("divu_by0", 4'b0110, 1'b1, 32'd5, 32'd0, 21'd0, 32'hFFFFFFFF, 4'b1010, 1, 0, 33);
        issue("remu_by0", 4'b0111, 1'b1, 32'd5, 32'd0, 21'd0, 32'd5, 4'b1010, 1, 0, 33);

        // Back-to-back single-cycle ops with out_ready held high.
        issue("sub", 4'b0011, 1'b1, 32'd5, 32'd7, 21'd0, 32'hFFFFFFFE, 4'b0110, 0, 0, 1);
        issue("and", 4'b1000, 1'b1, 32'hF0, 32'h3C, 21'd0, 32'h30, 4'b1010, 0, 0, 1);
        issue("orr", 4'b1001, 1'b1, 32'hF0, 32'h3C, 21'd0, 32'hFC, 4'b1010, 0, 0, 1);
        issue("eor", 4'b1010, 1'b1, 32'hF0, 32'h3C, 21'd0, 32'hCC, 4'b1010, 0, 0, 1);
        issue("lsr", 4'b1101, 1'b0, 32'h80000000, 32'd0, 21'd31, 32'd1, 4'b1010, 0, 0, 1);
        issue("lsl", 4'b1100, 1'b1, 32'h3, 32'd4, 21'd0, 32'h30, 4'b0110, 0, 0, 1);
        issue("ldr", 4'b0000, 1'b1, 32'd9, 32'd9, 21'd0, 32'd9, 4'b0001, 0, 0, 1);
        drain();

        // Output stall with a new request waiting behind it.
        out_ready = 1'b0;
        issue("stall_add", 4'b0010, 1'b1, 32'd1, 32'd1, 21'd0, 32'd2, 4'b0001, 0, 0, 1);
        exp32.push_back('{nm: "lsl_over", res: 32'd0, cmp: 4'b0110, dz: 1'b0, ill: 1'b0, lat: 1});
        opcode = 4'b1100; addressing_mode = 1'b1; reg_a_data = 32'd1; reg_b_data = 32'd40;
        in_valid = 1'b1;
        repeat (5) begin
            @(negedge clk);
            chk("stall.in_ready", {31'd0, in_ready}, 32'd0);
            chk("stall.out_valid", {31'd0, out_valid}, 32'd1);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        @(negedge clk);
        chk("release.in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        drain();

        // Reset in the middle of a divide aborts it.
        issue("divu_abort", 4'b0110, 1'b1, 32'd100, 32'd7, 21'd0, 32'd14, 4'b1010, 0, 0, 33);
        repeat (9) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("abort.out_valid", {31'd0, out_valid}, 32'd0);
        chk("abort.cmp", {28'd0, cmp_result}, 32'd1);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        #1 chk("abort.in_ready", {31'd0, in_ready}, 32'd1);
        issue("cmp_eq", 4'b1110, 1'b1, 32'd3, 32'd3, 21'd0, 32'd0, 4'b0001, 0, 0, 1);
        issue("illegal", 4'b1111, 1'b1, 32'd3, 32'd9, 21'd0, 32'd0, 4'b0110, 0, 1, 1);
        drain();

        issue8("mul8", 4'b0101, 1'b1, 8'h0F, 8'h11, 4'd0, 8'hFF, 4'b0110, 9);
        issue8("divu8", 4'b0110, 1'b1, 8'hFF, 8'h10, 4'd0, 8'h0F, 4'b1010, 9);
        issue8("ldr_imm8", 4'b0000, 1'b0, 8'h00, 8'h00, 4'hA, 8'h0A, 4'b0110, 1);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
